input_event_latch: RTL
======================

Name: input_event_latch

Overview:
- Downstream consumer of a bank of input filter instances (limit switches, wire-break, alarm inputs) in the CNC controller.
- Per channel: takes the filtered level, ready and timeout flags; qualifies edges only after the filter is ready; latches masked rising/falling events and timeout faults into sticky status bits.
- Presents status, fault and a combined interrupt to the CPU register bank, with write-1-to-clear semantics.

Parameters:
- CHANNELS, 8, number of independent input channels (1..32).

Ports:
- clock  in  1  system clock
- sclr  in  1  synchronous active-high reset
- in_level  in  CHANNELS  filtered level per channel (filter out)
- in_ready  in  CHANNELS  filter ready per channel
- in_timeout  in  CHANNELS  filter timeout (stuck mid-state) per channel
- rise_ena  in  CHANNELS  enable rising-edge event latching
- fall_ena  in  CHANNELS  enable falling-edge event latching
- clr_we  in  1  clear strobe, one cycle
- clr_mask  in  CHANNELS  bits to clear in status and fault when clr_we=1
- level  out  CHANNELS  qualified level (registered)
- status  out  CHANNELS  sticky edge-event flags
- fault  out  CHANNELS  sticky timeout-fault flags
- valid  out  CHANNELS  1 while channel is in ARMED
- irq  out  1  registered OR of all status and fault bits

Behaviour:
- Only the clock and sclr ports exist for clocking/reset: one clock; reset is synchronous and active-high.
- Reset, evaluated on the clock edge: all outputs = 0 and every channel FSM = ST_INIT. Reset mid-operation discards pending events.
- Per-channel FSM states: ST_INIT, ST_ARMED, ST_FAULT.
- ST_INIT:
  - level=0, valid=0.
  - On in_ready=1 (and in_timeout=0): go to ST_ARMED and load level<=in_level. No event is generated on this arming load.
- ST_ARMED:
  - valid=1, level<=in_level every cycle.
  - Edge = in_level != level register.
  - Rising (level 0, in_level 1) with rise_ena=1: status bit set.
  - Falling (level 1, in_level 0) with fall_ena=1: status bit set.
  - Edge with the corresponding enable = 0: level updates, no status change.
- ST_ARMED exits (highest priority first):
  - in_ready=0: ST_INIT. No event; level<=0 next cycle.
  - in_timeout=1: ST_FAULT. fault bit set; level holds its last value; no edge event in that cycle.
- ST_FAULT:
  - valid=0, level frozen.
  - in_ready=0: ST_INIT.
  - in_timeout=0 and in_ready=1: ST_ARMED with silent level reload, same as arming.
  - fault stays set until cleared by software.
- Latency:
  - in_level change sampled at edge N: level and status visible after edge N.
  - irq visible after edge N+1 (registered from status/fault).
- Clear rules:
  - clr_we=1 clears status[i] and fault[i] for every clr_mask[i]=1.
  - Set and clear of the same bit in the same cycle: set wins.
  - clr_we=0: clr_mask is ignored.
- Enable masks affect only new events; changing a mask never sets or clears existing status bits.
- irq = |status | |fault, registered. It deasserts one cycle after the clear takes effect.
- Simultaneous events on multiple channels are all latched in the same cycle; channels are independent.

Decomposition:
- Package input_event_pkg: typedef enum logic [1:0] state_t {ST_INIT, ST_ARMED, ST_FAULT}; constant MAX_CHANNELS=32.
- Sub-module input_event_channel: one FSM, level, status and fault bits. Ports: clock, sclr, in_level, in_ready, in_timeout, rise_ena, fall_ena, clr; outputs level, status, fault, valid.
- Top-level: generate loop over CHANNELS plus the registered irq reduction.

Test Plan:
- Arming: ch0 in_level=1, in_ready 0->1 at cycle 10 -> valid[0]=1 and level[0]=1 from cycle 11; status[0]=0; irq stays 0.
- Rising event: ch2 armed level 0, rise_ena[2]=1; in_level[2]=1 at edge 20 -> status=0x04 after edge 20, irq=1 after edge 21. Falling edge with fall_ena[2]=0 -> status unchanged.
- Timeout fault: ch5 armed level 1, in_timeout[5]=1 -> fault=0x20, valid[5]=0, level[5]=1 frozen. Later in_timeout=0 with in_level=0 -> re-armed, level[5]=0, status[5] not set.
- Clear collision: status[1]=1; clr_we=1 with clr_mask=0x02 in the same cycle as a new rising event on ch1 -> status[1] stays 1. Next cycle clr_we=1 alone -> status[1]=0, irq=0 one cycle later.
- Ready drop: ch3 armed level 1, in_ready[3] 1->0 -> ST_INIT, level[3]=0, valid[3]=0, no fall event even with fall_ena[3]=1.
- Reset mid-operation: status=0xFF, fault=0x0F, irq=1; sclr=1 for one cycle -> all outputs 0 after that edge; channels re-arm only on the next in_ready=1 sample.

Source files
------------

// File: rtl/input_event_pkg.sv
// Shared types for the input event latch: per-channel FSM states
// and the supported channel count ceiling.
package input_event_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam int unsigned MAX_CHANNELS = 32;

endpackage

// File: rtl/input_event_channel.sv
// One input channel: qualifies edges once the filter is ready and keeps
// sticky edge-event and timeout-fault flags with write-1-to-clear.
module input_event_channel
    import input_event_pkg::*;
(
    input  logic clock,
    input  logic sclr,
    input  logic in_level,
    input  logic in_ready,
    input  logic in_timeout,
    input  logic rise_ena,
    input  logic fall_ena,
    input  logic clr,
    output logic level,
    output logic status,
    output logic fault,
    output logic valid
);

    state_t state_q, state_d;
    logic   level_q, level_d;
    logic   status_q, status_d;
    logic   fault_q, fault_d;
    logic   set_ev;
    logic   set_flt;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        set_ev  = 1'b0;
        set_flt = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                if (in_ready && !in_timeout) begin
                    state_d = ST_ARMED;
                    level_d = in_level;
                end
            end
            ST_ARMED: begin
                if (!in_ready) begin
                    state_d = ST_INIT;
                    level_d = 1'b0;
                end else if (in_timeout) begin
                    state_d = ST_FAULT;
                    set_flt = 1'b1;
                end else begin
                    level_d = in_level;
                    set_ev  = (in_level & ~level_q & rise_ena)
                            | (~in_level & level_q & fall_ena);
                end
            end
            ST_FAULT: begin
                // Re-arming reloads the level silently, like the first arm.
                if (!in_ready) begin
                    state_d = ST_INIT;
                    level_d = 1'b0;
                end else if (!in_timeout) begin
                    state_d = ST_ARMED;
                    level_d = in_level;
                end
            end
            default: begin
                state_d = ST_INIT;
                level_d = 1'b0;
            end
        endcase
        status_d = (status_q & ~clr) | set_ev;
        fault_d  = (fault_q & ~clr) | set_flt;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q  <= ST_INIT;
            level_q  <= 1'b0;
            status_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            status_q <= status_d;
            fault_q  <= fault_d;
        end
    end

    assign level  = level_q;
    assign status = status_q;
    assign fault  = fault_q;
    assign valid  = (state_q == ST_ARMED);

endmodule

// File: rtl/input_event_latch.sv
// Bank of input event channels with a registered combined interrupt
// for the CPU register block.
module input_event_latch
    import input_event_pkg::*;
#(
    parameter int unsigned CHANNELS = 8
) (
    input  logic                clock,
    input  logic                sclr,
    input  logic [CHANNELS-1:0] in_level,
    input  logic [CHANNELS-1:0] in_ready,
    input  logic [CHANNELS-1:0] in_timeout,
    input  logic [CHANNELS-1:0] rise_ena,
    input  logic [CHANNELS-1:0] fall_ena,
    input  logic                clr_we,
    input  logic [CHANNELS-1:0] clr_mask,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] status,
    output logic [CHANNELS-1:0] fault,
    output logic [CHANNELS-1:0] valid,
    output logic                irq
);

    logic [CHANNELS-1:0] clr;
    logic                irq_q, irq_d;

    assign clr = clr_mask & {CHANNELS{clr_we}};

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        input_event_channel u_ch (
            .clock      (clock),
            .sclr       (sclr),
            .in_level   (in_level[i]),
            .in_ready   (in_ready[i]),
            .in_timeout (in_timeout[i]),
            .rise_ena   (rise_ena[i]),
            .fall_ena   (fall_ena[i]),
            .clr        (clr[i]),
            .level      (level[i]),
            .status     (status[i]),
            .fault      (fault[i]),
            .valid      (valid[i])
        );
    end

    always_comb begin
        irq_d = (|status) | (|fault);
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
